// File: rtl/core_v_xif_pkg.sv
// CORE-V-XIF transaction types shared by the coprocessor cluster and the core.
package core_v_xif_pkg;

    localparam int X_ID_WIDTH = 4;
    localparam int X_MAX_CH   = 8;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [31:0]           data;
        logic [4:0]            rd;
        logic                  we;
        logic                  exc;
        logic [5:0]            exccode;
    } x_result_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  x_commit_kill;
    } x_commit_t;

endpackage

// File: rtl/xif_result_arbiter_pkg.sv
// Local constants and the round-robin search helper for xif_result_arbiter.
package xif_result_arbiter_pkg;

    import core_v_xif_pkg::*;

    localparam int CH_IDX_W   = 3;
    localparam int KILL_MAP_W = 2 ** X_ID_WIDTH;

    typedef logic [CH_IDX_W-1:0] ch_idx_t;

    // First set bit of elig strictly after ptr, wrapping within num_ch channels.
    function automatic ch_idx_t rr_pick(input logic [X_MAX_CH-1:0] elig,
                                        input ch_idx_t             ptr,
                                        input int                  num_ch);
        ch_idx_t pick;
        logic    found;
        int      idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 1; i <= X_MAX_CH; i++) begin
            if (i <= num_ch) begin
                idx = (int'(ptr) + i) % num_ch;
                if (!found && elig[idx[2:0]]) begin
                    pick  = idx[2:0];
                    found = 1'b1;
                end else begin
                    found = found;
                end
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/xif_result_arbiter_if.sv
// Result/commit bundle between the coprocessor cluster, the merger and the core.
interface xif_result_arbiter_if #(
    parameter int NUM_CH = 2
);
    import core_v_xif_pkg::*;

    logic [NUM_CH-1:0]     ch_result_valid_i;
    logic [NUM_CH-1:0]     ch_result_ready_o;
    x_result_t [NUM_CH-1:0] ch_result_i;
    logic                  result_valid_o;
    logic                  result_ready_i;
    x_result_t             result_o;
    logic                  commit_valid_i;
    x_commit_t             commit_i;
    logic [15:0]           drop_cnt_o;

    modport slave (
        input  ch_result_valid_i, ch_result_i, result_ready_i, commit_valid_i, commit_i,
        output ch_result_ready_o, result_valid_o, result_o, drop_cnt_o
    );

    modport master (
        output ch_result_valid_i, ch_result_i, result_ready_i, commit_valid_i, commit_i,
        input  ch_result_ready_o, result_valid_o, result_o, drop_cnt_o
    );

endinterface

// File: rtl/xif_result_fifo.sv
// Per-channel result FIFO with full/empty flags and synchronous reset.
module xif_result_fifo
    import core_v_xif_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      i_push,
    input  x_result_t i_data,
    input  logic      i_pop,
    output x_result_t o_data,
    output logic      o_full,
    output logic      o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   COUNT_ONE = (AW + 1)'(1);

    x_result_t   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == (AW + 1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rptr];

    // Storage array, written at the tail pointer.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + COUNT_ONE;
                2'b01:   r_count <= r_count - COUNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/xif_result_arbiter.sv
// Round-robin merger of NUM_CH coprocessor result channels onto one XIF result port.
// Optional kill filter enabled by defining XIF_RESULT_KILL_FILTER_EN.
module xif_result_arbiter
    import core_v_xif_pkg::*;
    import xif_result_arbiter_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    xif_result_arbiter_if.slave  bus
);

    logic [NUM_CH-1:0]   w_full;
    logic [NUM_CH-1:0]   w_empty;
    logic [NUM_CH-1:0]   w_ready;
    logic [NUM_CH-1:0]   w_push;
    logic [NUM_CH-1:0]   w_write;
    logic [NUM_CH-1:0]   w_pop;
    logic [X_MAX_CH-1:0] w_elig;
    x_result_t           w_fifo_data [X_MAX_CH];
    ch_idx_t             w_grant;
    logic                w_valid;
    logic                w_hs;
    ch_idx_t             r_rr_ptr;
    ch_idx_t             r_lock_ch;
    logic                r_locked;

    assign w_ready               = rst_i ? {NUM_CH{1'b0}} : ~w_full;
    assign w_push                = bus.ch_result_valid_i & w_ready;
    assign bus.ch_result_ready_o = w_ready;

    // Eligible set, widened to the package maximum for the search helper.
    always_comb begin
        w_elig               = '0;
        w_elig[NUM_CH-1:0]   = ~w_empty;
    end

    // A stalled presentation keeps its channel so late arrivals cannot pre-empt it.
    assign w_grant = r_locked ? r_lock_ch : rr_pick(w_elig, r_rr_ptr, NUM_CH);
    assign w_valid = |(~w_empty);
    assign w_hs    = w_valid & bus.result_ready_i;

    // Pop strobe for the granted FIFO on output handshake.
    always_comb begin
        w_pop = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_pop[c] = w_hs & (w_grant == ch_idx_t'(c));
        end
    end

    assign bus.result_valid_o = w_valid;
    assign bus.result_o       = w_valid ? w_fifo_data[w_grant] : '0;

    // Priority pointer and stall lock.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr  <= ch_idx_t'(NUM_CH - 1);
            r_locked  <= 1'b0;
            r_lock_ch <= '0;
        end else if (w_hs) begin
            r_rr_ptr  <= w_grant;
            r_locked  <= 1'b0;
        end else if (w_valid) begin
            r_locked  <= 1'b1;
            r_lock_ch <= w_grant;
        end else begin
            r_locked  <= 1'b0;
        end
    end

    for (genvar g = 0; g < X_MAX_CH; g++) begin : g_ch
        if (g < NUM_CH) begin : g_fifo
            xif_result_fifo #(
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .i_push  (w_write[g]),
                .i_data  (bus.ch_result_i[g]),
                .i_pop   (w_pop[g]),
                .o_data  (w_fifo_data[g]),
                .o_full  (w_full[g]),
                .o_empty (w_empty[g])
            );
        end else begin : g_tie
            assign w_fifo_data[g] = '0;
        end
    end

`ifdef XIF_RESULT_KILL_FILTER_EN
    logic [KILL_MAP_W-1:0] r_killed;
    logic [KILL_MAP_W-1:0] w_killed_nxt;
    logic [NUM_CH-1:0]     w_hit;
    logic [4:0]            w_drop_num;
    logic [16:0]           w_cnt_sum;
    logic [15:0]           r_drop_cnt;

    // Kill lookup per channel; drop clears are applied after the commit update so they win.
    always_comb begin
        w_killed_nxt = r_killed;
        w_hit        = '0;
        w_drop_num   = 5'd0;
        if (bus.commit_valid_i) begin
            w_killed_nxt[bus.commit_i.id] = bus.commit_i.x_commit_kill;
        end else begin
            w_killed_nxt = r_killed;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            w_hit[c] = r_killed[bus.ch_result_i[c].id]
                     | (bus.commit_valid_i & bus.commit_i.x_commit_kill
                        & (bus.commit_i.id == bus.ch_result_i[c].id));
            w_killed_nxt[bus.ch_result_i[c].id] = w_killed_nxt[bus.ch_result_i[c].id]
                                                & ~(w_push[c] & w_hit[c]);
            w_drop_num = w_drop_num + {4'd0, w_push[c] & w_hit[c]};
        end
    end

    assign w_write    = w_push & ~w_hit;
    assign w_cnt_sum  = {1'b0, r_drop_cnt} + {12'd0, w_drop_num};
    assign bus.drop_cnt_o = r_drop_cnt;

    // Kill bitmap and saturating drop counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_killed   <= '0;
            r_drop_cnt <= 16'd0;
        end else begin
            r_killed   <= w_killed_nxt;
            r_drop_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
        end
    end
`else
    logic w_unused_commit;

    assign w_write         = w_push;
    assign bus.drop_cnt_o  = 16'd0;
    assign w_unused_commit = ^{bus.commit_valid_i, bus.commit_i};
`endif

endmodule

// File: tb/tb_xif_result_arbiter.sv
// Directed and randomized bench for xif_result_arbiter against a queue-based reference model.
module tb_xif_result_arbiter;
    import core_v_xif_pkg::*;

    localparam int NUM_CH = 3;
    localparam int DEPTH  = 2;
`ifdef XIF_RESULT_KILL_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    xif_result_arbiter_if #(.NUM_CH(NUM_CH)) bus ();

    xif_result_arbiter #(
        .NUM_CH     (NUM_CH),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    x_result_t mq [NUM_CH][$];
    int        m_ptr;
    int        m_held;
    bit [15:0] m_killed;
    int        m_cnt;
    int        n_assert = 0;
    int        n_fail   = 0;

    function automatic x_result_t mk(input logic [3:0] id, input logic [31:0] data);
        x_result_t r;
        r      = '0;
        r.id   = id;
        r.data = data;
        r.rd   = data[4:0];
        r.we   = 1'b1;
        return r;
    endfunction

    function automatic int m_present();
        int c;
        if (m_held >= 0) return m_held;
        for (int i = 1; i <= NUM_CH; i++) begin
            c = (m_ptr + i) % NUM_CH;
            if (mq[c].size() > 0) return c;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_update();
        int              p;
        int              drops;
        bit [NUM_CH-1:0] rdy;
        bit [15:0]       nk;
        x_result_t       d;
        p = m_present();
        for (int c = 0; c < NUM_CH; c++) rdy[c] = !rst && (mq[c].size() < DEPTH);
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) mq[c].delete();
            m_ptr    = NUM_CH - 1;
            m_held   = -1;
            m_killed = '0;
            m_cnt    = 0;
            return;
        end
        if (p >= 0 && bus.result_ready_i) begin
            void'(mq[p].pop_front());
            m_ptr  = p;
            m_held = -1;
        end else if (p >= 0) begin
            m_held = p;
        end
        nk    = m_killed;
        drops = 0;
        if (FILTER && bus.commit_valid_i) nk[bus.commit_i.id] = bus.commit_i.x_commit_kill;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.ch_result_valid_i[c] && rdy[c]) begin
                d = bus.ch_result_i[c];
                if (FILTER && (m_killed[d.id] || (bus.commit_valid_i && bus.commit_i.x_commit_kill
                                                  && bus.commit_i.id == d.id))) begin
                    drops++;
                    nk[d.id] = 1'b0;
                end else begin
                    mq[c].push_back(d);
                end
            end
        end
        m_killed = nk;
        m_cnt    = (m_cnt + drops > 65535) ? 65535 : m_cnt + drops;
    endtask

    task automatic check_outputs();
        int              p;
        x_result_t       er;
        logic [NUM_CH-1:0] erdy;
        p  = m_present();
        er = (p >= 0) ? mq[p][0] : '0;
        for (int c = 0; c < NUM_CH; c++) erdy[c] = !rst && (mq[c].size() < DEPTH);
        chk("result_valid", 64'(bus.result_valid_o), 64'(p >= 0));
        chk("result_o", 64'(bus.result_o), 64'(er));
        chk("ch_ready", 64'(bus.ch_result_ready_o), 64'(erdy));
        chk("drop_cnt", 64'(bus.drop_cnt_o), 64'(m_cnt));
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        bus.ch_result_valid_i = '0;
        for (int c = 0; c < NUM_CH; c++) bus.ch_result_i[c] = '0;
        bus.commit_valid_i = 1'b0;
        bus.commit_i       = '0;
    endtask

    task automatic commit(input logic [3:0] id, input bit kill);
        bus.commit_valid_i         = 1'b1;
        bus.commit_i.id            = id;
        bus.commit_i.x_commit_kill = kill;
    endtask

    initial begin
        m_ptr    = NUM_CH - 1;
        m_held   = -1;
        m_killed = '0;
        m_cnt    = 0;
        rst      = 1'b1;
        idle_inputs();
        bus.result_ready_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Single result id=3 appears one cycle after its push and leaves on handshake.
        bus.result_ready_i       = 1'b1;
        bus.ch_result_valid_i[0] = 1'b1;
        bus.ch_result_i[0]       = mk(4'd3, 32'hA5A5_0003);
        step();
        chk("single_id", 64'(bus.result_o.id), 64'd3);
        idle_inputs();
        step();
        chk("single_gone", 64'(bus.result_valid_o), 64'd0);

        // All channels pushing with the core always ready.
        for (int k = 0; k < 9; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                bus.ch_result_valid_i[c] = 1'b1;
                bus.ch_result_i[c]       = mk(4'(c), 32'(c * 256 + k));
            end
            step();
        end
        idle_inputs();
        for (int k = 0; k < 6; k++) step();

        // Stall while channel 1 is presented and channel 0 fills, then release.
        bus.result_ready_i       = 1'b0;
        bus.ch_result_valid_i[1] = 1'b1;
        bus.ch_result_i[1]       = mk(4'd1, 32'h1111_0000);
        step();
        bus.ch_result_valid_i[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.ch_result_valid_i[0] = 1'b1;
            bus.ch_result_i[0]       = mk(4'd0, 32'h0000_0100 + 32'(k));
            step();
            chk("lock_ch1", 64'(bus.result_o.data), 64'h1111_0000);
        end
        idle_inputs();
        bus.result_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) step();

        // Three back-to-back pushes on channel 0 against a stalled output.
        bus.result_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.ch_result_valid_i[0] = 1'b1;
            bus.ch_result_i[0]       = mk(4'd2, 32'h0000_0200 + 32'(k));
            step();
        end
        chk("full_ready0", 64'(bus.ch_result_ready_o[0]), 64'd0);
        bus.result_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) step();
        idle_inputs();
        for (int k = 0; k < 3; k++) step();

        // Kill id=5 then push it twice on channel 1.
        commit(4'd5, 1'b1);
        step();
        idle_inputs();
        bus.ch_result_valid_i[1] = 1'b1;
        bus.ch_result_i[1]       = mk(4'd5, 32'h5555_0001);
        step();
        bus.ch_result_valid_i[1] = 1'b0;
        step();
        bus.ch_result_valid_i[1] = 1'b1;
        bus.ch_result_i[1]       = mk(4'd5, 32'h5555_0002);
        step();
        idle_inputs();
        step();

        // Kill id=7 in the same cycle as its push; then a non-kill commit before a push.
        commit(4'd7, 1'b1);
        bus.ch_result_valid_i[2] = 1'b1;
        bus.ch_result_i[2]       = mk(4'd7, 32'h7777_0001);
        step();
        idle_inputs();
        commit(4'd7, 1'b1);
        step();
        commit(4'd7, 1'b0);
        step();
        idle_inputs();
        bus.ch_result_valid_i[2] = 1'b1;
        bus.ch_result_i[2]       = mk(4'd7, 32'h7777_0002);
        step();
        idle_inputs();
        step();

        // Randomized traffic, back-pressure and commits.
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                bus.ch_result_valid_i[c] = ($urandom_range(0, 99) < 55);
                bus.ch_result_i[c]       = mk(4'($urandom_range(0, 15)), $urandom);
            end
            bus.result_ready_i = ($urandom_range(0, 99) < 65);
            if ($urandom_range(0, 99) < 30) commit(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            else bus.commit_valid_i = 1'b0;
            step();
        end

        // Reset in the middle of a stalled transfer discards everything.
        idle_inputs();
        bus.result_ready_i = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            bus.ch_result_valid_i[c] = 1'b1;
            bus.ch_result_i[c]       = mk(4'(c + 8), 32'hDEAD_0000 + 32'(c));
        end
        step();
        step();
        rst = 1'b1;
        step();
        chk("rst_valid", 64'(bus.result_valid_o), 64'd0);
        rst = 1'b0;
        idle_inputs();
        bus.result_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
